// File: rtl/vec_alu_pkg.sv
// Shared types for the vector ALU sequencer: FSM state encoding and opcode width.
package vec_alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO, power-of-two depth; count tells full apart from empty.
module cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vec_alu_sequencer.sv
// Buffers vector ALU commands, issues them one at a time, waits the ALU latency
// and presents masked lane results on a valid/ready result port.
module vec_alu_sequencer
  import vec_alu_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int N_ALU   = 1,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WIDTH*N_ALU-1:0]   cmd_a,
  input  logic [WIDTH*N_ALU-1:0]   cmd_b,
  input  logic [ALU_OP_W-1:0]      cmd_op,
  input  logic [N_ALU-1:0]         cmd_mask,
  output logic [WIDTH*N_ALU-1:0]   alu_a,
  output logic [WIDTH*N_ALU-1:0]   alu_b,
  output logic [ALU_OP_W-1:0]      alu_select,
  output logic [N_ALU-1:0]         alu_enable,
  input  logic [2*WIDTH*N_ALU-1:0] alu_data_out,
  input  logic [N_ALU-1:0]         alu_inf,
  input  logic                     alu_carry_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [2*WIDTH*N_ALU-1:0] res_data,
  output logic [N_ALU-1:0]         res_inf,
  output logic                     res_carry,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output state_e                   dbg_state
);

  localparam int LANE_BITS = WIDTH * N_ALU;
  localparam int RES_BITS  = 2 * WIDTH * N_ALU;
  localparam int CNT_W     = $clog2(ALU_LAT + 1);

  typedef struct packed {
    logic [LANE_BITS-1:0] a;
    logic [LANE_BITS-1:0] b;
    logic [ALU_OP_W-1:0]  op;
    logic [N_ALU-1:0]     mask;
  } cmd_t;

  cmd_t               wr_cmd;
  cmd_t               head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               capture;
  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   exec_cnt;
  logic [RES_BITS-1:0] data_masked;

  // Handshakes: a transfer happens on an edge where valid && ready are both high;
  // valid never depends on ready, and payload is held while valid waits.
  assign cmd_ready = !fifo_full && !arst;
  assign push      = cmd_valid && cmd_ready;
  assign wr_cmd    = '{a: cmd_a, b: cmd_b, op: cmd_op, mask: cmd_mask};

  cmd_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .arst  (arst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_cmd),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: if (exec_cnt == CNT_W'(ALU_LAT)) begin
        capture   = 1'b1;
        state_nxt = DONE;
      end
      DONE: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  // alu_enable still carries the issued mask during EXEC, so it gates the capture.
  always_comb begin
    data_masked = '0;
    for (int i = 0; i < N_ALU; i++) begin
      data_masked[i*2*WIDTH +: 2*WIDTH] =
        alu_enable[i] ? alu_data_out[i*2*WIDTH +: 2*WIDTH] : '0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= '0;
      alu_enable <= '0;
      exec_cnt   <= '0;
      res_data   <= '0;
      res_inf    <= '0;
      res_carry  <= 1'b0;
    end else begin
      if (pop) begin
        alu_a      <= head.a;
        alu_b      <= head.b;
        alu_select <= head.op;
        alu_enable <= head.mask;
        exec_cnt   <= '0;
      end else if (capture) begin
        res_data   <= data_masked;
        res_inf    <= alu_inf & alu_enable;
        res_carry  <= alu_carry_out;
        alu_enable <= '0;
      end else if (state == EXEC) begin
        exec_cnt   <= exec_cnt + 1'b1;
      end
    end
  end

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE) || !fifo_empty;
  assign dbg_state = state;

endmodule
